// File: rtl/iom_master.sv
// iom_master: initiator side of the MicroBlaze MCS IO bus.
//
// Accepts single read/write commands on a valid/ready channel, runs one IO
// bus transaction per command (one-cycle address strobe with read/write
// qualifier, then a wait for io_ready) and returns read data or a bus error
// on a valid/ready response channel. One transaction outstanding at a time.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_*                command channel (valid/ready, write flag, 12-bit
//                        address, 4-bit byte enable, 32-bit write data)
//   rsp_*                response channel (valid/ready, 32-bit read data,
//                        error flag = timeout)
//   io_*                 IO bus: strobes, held address/byte enable/write
//                        data, responder read data and ready pulse
//
// Parameter:
//   TIMEOUT_CYCLES       cycles to wait for io_ready after the strobe (1..65535)
//
// Configuration macro:
//   IOM_MASTER_TIMEOUT_EN  when defined, a saturating timeout counter ends
//                          WAIT with an error response; when undefined, WAIT
//                          only exits on io_ready and rsp_error is tied to 0.

module iom_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_address,
  input  logic [3:0]  cmd_byte_enable,
  input  logic [31:0] cmd_write_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_read_data,
  output logic        rsp_error,
  output logic        io_addr_strobe,
  output logic        io_read_strobe,
  output logic        io_write_strobe,
  output logic [11:0] io_address,
  output logic [3:0]  io_byte_enable,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_read_data_q, rsp_read_data_d;
  logic        io_addr_strobe_q, io_addr_strobe_d;
  logic        io_read_strobe_q, io_read_strobe_d;
  logic        io_write_strobe_q, io_write_strobe_d;
  logic [11:0] io_address_q, io_address_d;
  logic [3:0]  io_byte_enable_q, io_byte_enable_d;
  logic [31:0] io_write_data_q, io_write_data_d;
  logic        write_q, write_d;

`ifdef IOM_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // WAIT cycle j (1-based) sees cnt_q == j-1, so the last allowed cycle is
  // the one where cnt_q == TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_error_q, rsp_error_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d           = state_q;
    cmd_ready_d       = cmd_ready_q;
    rsp_valid_d       = rsp_valid_q;
    rsp_read_data_d   = rsp_read_data_q;
    io_addr_strobe_d  = 1'b0;
    io_read_strobe_d  = 1'b0;
    io_write_strobe_d = 1'b0;
    io_address_d      = io_address_q;
    io_byte_enable_d  = io_byte_enable_q;
    io_write_data_d   = io_write_data_q;
    write_d           = write_q;
`ifdef IOM_MASTER_TIMEOUT_EN
    cnt_d             = cnt_q;
    rsp_error_d       = rsp_error_q;
`endif

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d       = 1'b0;
          write_d           = cmd_write;
          io_address_d      = cmd_address;
          io_byte_enable_d  = cmd_byte_enable;
          io_write_data_d   = cmd_write_data;
          io_addr_strobe_d  = 1'b1;
          io_read_strobe_d  = ~cmd_write;
          io_write_strobe_d = cmd_write;
          state_d           = S_STROBE;
        end
      end

      S_STROBE: begin
`ifdef IOM_MASTER_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (io_ready) begin
          rsp_read_data_d = write_q ? '0 : io_read_data;
          rsp_valid_d     = 1'b1;
`ifdef IOM_MASTER_TIMEOUT_EN
          rsp_error_d     = 1'b0;
`endif
          state_d         = S_RESP;
        end
`ifdef IOM_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_read_data_d = '0;
          rsp_error_d     = 1'b1;
          rsp_valid_d     = 1'b1;
          state_d         = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      cmd_ready_q       <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_read_data_q   <= '0;
      io_addr_strobe_q  <= 1'b0;
      io_read_strobe_q  <= 1'b0;
      io_write_strobe_q <= 1'b0;
      io_address_q      <= '0;
      io_byte_enable_q  <= '0;
      io_write_data_q   <= '0;
      write_q           <= 1'b0;
`ifdef IOM_MASTER_TIMEOUT_EN
      cnt_q             <= '0;
      rsp_error_q       <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      cmd_ready_q       <= cmd_ready_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_read_data_q   <= rsp_read_data_d;
      io_addr_strobe_q  <= io_addr_strobe_d;
      io_read_strobe_q  <= io_read_strobe_d;
      io_write_strobe_q <= io_write_strobe_d;
      io_address_q      <= io_address_d;
      io_byte_enable_q  <= io_byte_enable_d;
      io_write_data_q   <= io_write_data_d;
      write_q           <= write_d;
`ifdef IOM_MASTER_TIMEOUT_EN
      cnt_q             <= cnt_d;
      rsp_error_q       <= rsp_error_d;
`endif
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_read_data   = rsp_read_data_q;
  assign io_addr_strobe  = io_addr_strobe_q;
  assign io_read_strobe  = io_read_strobe_q;
  assign io_write_strobe = io_write_strobe_q;
  assign io_address      = io_address_q;
  assign io_byte_enable  = io_byte_enable_q;
  assign io_write_data   = io_write_data_q;
`ifdef IOM_MASTER_TIMEOUT_EN
  assign rsp_error       = rsp_error_q;
`else
  assign rsp_error       = 1'b0;
`endif

endmodule

// File: tb/tb_iom_master.sv
// tb_iom_master: scoreboard bench for iom_master (TIMEOUT_CYCLES = 4).
// The driver issues commands, plays the IO responder and consumes responses;
// a negedge monitor pops expected strobes/responses from queues and compares.
// Works with or without IOM_MASTER_TIMEOUT_EN defined.

module tb_iom_master;

  localparam int unsigned T = 4;
`ifdef IOM_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_address = '0;
  logic [3:0]  cmd_byte_enable = '0;
  logic [31:0] cmd_write_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_read_data;
  logic        rsp_error;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [11:0] io_address;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data = '0;
  logic        io_ready = 1'b0;

  iom_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_byte_enable(cmd_byte_enable),
    .cmd_write_data(cmd_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_read_data(rsp_read_data), .rsp_error(rsp_error),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  // cyc read at a negedge equals the cycle number of that cycle
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } str_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  str_t str_q[$];
  rsp_t rsp_q[$];

  int unsigned total = 0;
  int unsigned bad = 0;

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void note_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: event not as required", name);
  endfunction

  // Expected response from the bus rules: reads return responder data,
  // writes return 0; no ready within T wait cycles means an error response
  // one cycle after the last allowed wait cycle.
  function automatic rsp_t model(input logic wr, input logic [31:0] rd,
                                 input int unsigned k, input bit silent,
                                 input int unsigned n);
    rsp_t r;
    if (TO_EN && (silent || k > T)) begin
      r.cyc = n + 2 + T; r.data = '0; r.err = 1'b1;
    end else begin
      r.cyc = n + 2 + k; r.data = wr ? 32'h0 : rd; r.err = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [95:0] all_outputs();
    return {10'b0, cmd_ready, rsp_valid, rsp_error, rsp_read_data,
            io_addr_strobe, io_read_strobe, io_write_strobe,
            io_address, io_byte_enable, io_write_data};
  endfunction

  // ---------------- monitor ----------------
  bit          prev_valid = 1'b0;
  bit          prev_strobe = 1'b0;
  rsp_t        cur;
  logic [11:0] held_addr = '0;

  always @(negedge clk) begin
    str_t s;
    if (!rst_n) begin
      prev_valid  = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      if (io_addr_strobe) begin
        if (prev_strobe) note_fail("strobe_longer_than_one_cycle");
        if (str_q.size() == 0) note_fail("unexpected_strobe");
        else begin
          s = str_q.pop_front();
          check("strobe_cycle", 96'(cyc), 96'(s.cyc));
          check("strobe_addr", 96'(io_address), 96'(s.addr));
          check("strobe_be", 96'(io_byte_enable), 96'(s.be));
          check("strobe_wdata", 96'(io_write_data), 96'(s.wdata));
          check("strobe_rw", 96'({io_read_strobe, io_write_strobe}), 96'({~s.wr, s.wr}));
          held_addr = s.addr;
        end
      end else if (io_read_strobe || io_write_strobe) begin
        note_fail("qualifier_without_addr_strobe");
      end

      if (rsp_valid && !prev_valid) begin
        if (rsp_q.size() == 0) note_fail("unexpected_response");
        else begin
          cur = rsp_q.pop_front();
          check("rsp_cycle", 96'(cyc), 96'(cur.cyc));
          check("rsp_data", 96'(rsp_read_data), 96'(cur.data));
          check("rsp_error", 96'(rsp_error), 96'(cur.err));
        end
      end else if (rsp_valid) begin
        check("rsp_data_hold", 96'(rsp_read_data), 96'(cur.data));
        check("rsp_error_hold", 96'(rsp_error), 96'(cur.err));
        check("cmd_ready_low_in_resp", 96'(cmd_ready), 96'(0));
        check("io_address_hold", 96'(io_address), 96'(held_addr));
      end else if (prev_valid) begin
        check("cmd_ready_after_rsp", 96'(cmd_ready), 96'(1));
      end
      prev_valid  = rsp_valid;
      prev_strobe = io_addr_strobe;
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge of the STROBE cycle.
  task automatic issue(input logic wr, input logic [11:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int unsigned k, input bit silent, output bit ok);
    int unsigned n;
    int unsigned waited;
    cmd_write = wr; cmd_address = a; cmd_byte_enable = be; cmd_write_data = wd;
    cmd_valid = 1'b1;
    ok = 1'b0;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      note_fail("cmd_handshake_bound");
      cmd_valid = 1'b0;
      return;
    end
    ok = 1'b1;
    n = cyc;
    str_q.push_back('{n + 1, wr, a, be, wd});
    if (!silent || TO_EN) rsp_q.push_back(model(wr, rd, k, silent, n));
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_address = 12'($urandom);
    cmd_byte_enable = 4'($urandom); cmd_write_data = $urandom;
  endtask

  // io_ready high during cycle N+1+k (k wait cycles after the strobe).
  task automatic respond(input int unsigned k, input logic [31:0] rd);
    repeat (k) @(negedge clk);
    io_ready = 1'b1;
    io_read_data = rd;
    @(negedge clk);
    io_ready = 1'b0;
    io_read_data = $urandom;
  endtask

  task automatic collect(input int unsigned stall);
    int unsigned waited = 0;
    while (!rsp_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      note_fail("rsp_wait_bound");
      return;
    end
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run(input logic wr, input logic [11:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int unsigned k, input bit silent, input int unsigned stall);
    bit ok;
    issue(wr, a, be, wd, rd, k, silent, ok);
    if (!ok) return;
    if (!silent) respond(k, rd);
    collect(stall);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_outputs(), 96'(0));
    str_q.delete();
    rsp_q.delete();
    io_ready = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("cmd_ready_before_first_edge", 96'(cmd_ready), 96'(0));
    @(negedge clk);
    check("cmd_ready_after_release", 96'(cmd_ready), 96'(1));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int unsigned seen;
    #1 check("reset_outputs", all_outputs(), 96'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("cmd_ready_before_first_edge", 96'(cmd_ready), 96'(0));
    @(negedge clk);
    check("cmd_ready_after_release", 96'(cmd_ready), 96'(1));

    // PRNG-style responder write and read
    run(1'b1, 12'h000, 4'hF, 32'h12345678, 32'hDEAD0001, 1, 1'b0, 0);
    run(1'b0, 12'h004, 4'hF, 32'h00000000, 32'hCAFEF00D, 1, 1'b0, 0);
    // ready on the last allowed wait cycle
    run(1'b0, 12'h00C, 4'h3, 32'h0, 32'hA5A5A5A5, T, 1'b0, 0);

`ifdef IOM_MASTER_TIMEOUT_EN
    // silent responder, then a late io_ready at N+8 while the error is held
    run(1'b0, 12'h008, 4'hF, 32'h0, 32'h11111111, 7, 1'b0, 3);
    run(1'b1, 12'h01C, 4'h1, 32'h0BADBEEF, 32'h0, 0, 1'b1, 1);
`else
    // silent responder hangs the block until reset
    issue(1'b0, 12'h008, 4'hF, 32'h0, 32'h0, 0, 1'b1, ok);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("hang_no_rsp", 96'(seen), 96'(0));
    reset_pulse();
`endif

    // backpressure: response held for 10 cycles
    run(1'b0, 12'h010, 4'hC, 32'h0, 32'h5A5A1234, 2, 1'b0, 10);

    // reset during WAIT discards the transaction
    issue(1'b0, 12'h020, 4'hF, 32'h0, 32'h0, 0, 1'b1, ok);
    @(negedge clk);
    reset_pulse();

    // stray io_ready while idle
    io_ready = 1'b1;
    io_read_data = 32'hFFFFFFFF;
    @(negedge clk);
    io_ready = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || !cmd_ready || io_addr_strobe) seen++;
    end
    check("stray_ready_ignored", 96'(seen), 96'(0));

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit sil;
      sil = TO_EN && ($urandom_range(0, 5) == 0);
      run(1'($urandom), 12'($urandom), 4'($urandom), $urandom, $urandom,
          $urandom_range(1, 7), sil, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("rsp_queue_drained", 96'(rsp_q.size()), 96'(0));
    check("strobe_queue_drained", 96'(str_q.size()), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
